// File: rtl/wishbone_bus_if.sv
// CPU memory-port to Wishbone B4 classic master adapter: turns a single-cycle CPU
// access into a bus transaction, stalls the pipeline until ack and aborts on timeout.
//
//   state        | meaning
//   S_IDLE       | no bus activity, waiting for cpu_ce_i
//   S_BUSY       | stb/cyc asserted, waiting for wb_ack_i or timeout
//   S_WAIT_STALL | access done, holding read word until the pipeline stall clears
module wishbone_bus_if #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [5:0]          stall_i,
    input  logic                flush_i,
    input  logic                cpu_ce_i,
    input  logic [ADDR_W-1:0]   cpu_addr_i,
    input  logic [DATA_W-1:0]   cpu_data_i,
    input  logic                cpu_we_i,
    input  logic [DATA_W/8-1:0] cpu_sel_i,
    output logic [DATA_W-1:0]   cpu_data_o,
    output logic                stallreq_o,
    output logic                bus_err_o,
    input  logic [DATA_W-1:0]   wb_dat_i,
    input  logic                wb_ack_i,
    output logic [ADDR_W-1:0]   wb_adr_o,
    output logic [DATA_W-1:0]   wb_dat_o,
    output logic                wb_we_o,
    output logic [DATA_W/8-1:0] wb_sel_o,
    output logic                wb_stb_o,
    output logic                wb_cyc_o
);

    localparam int SEL_W = DATA_W / 8;
    localparam int CNT_W = (TIMEOUT_CYC < 1) ? 1 : $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_BUSY       = 2'd1,
        S_WAIT_STALL = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  adr_q, adr_d;
    logic [DATA_W-1:0]  dat_q, dat_d;
    logic               we_q, we_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic               stb_q, stb_d;
    logic [DATA_W-1:0]  rd_buf_q, rd_buf_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               bus_err_q, bus_err_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            adr_q     <= '0;
            dat_q     <= '0;
            we_q      <= 1'b0;
            sel_q     <= '0;
            stb_q     <= 1'b0;
            rd_buf_q  <= '0;
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            we_q      <= we_d;
            sel_q     <= sel_d;
            stb_q     <= stb_d;
            rd_buf_q  <= rd_buf_d;
            cnt_q     <= cnt_d;
            bus_err_q <= bus_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        adr_d      = adr_q;
        dat_d      = dat_q;
        we_d       = we_q;
        sel_d      = sel_q;
        stb_d      = stb_q;
        rd_buf_d   = rd_buf_q;
        cnt_d      = cnt_q;
        bus_err_d  = 1'b0;
        stallreq_o = 1'b0;
        cpu_data_o = '0;

        case (state_q)
            S_IDLE: begin
                if (cpu_ce_i && !flush_i) begin
                    adr_d      = cpu_addr_i;
                    dat_d      = cpu_data_i;
                    we_d       = cpu_we_i;
                    sel_d      = cpu_sel_i;
                    stb_d      = 1'b1;
                    cnt_d      = '0;
                    state_d    = S_BUSY;
                    stallreq_o = 1'b1;
                end
            end

            S_BUSY: begin
                // Any exit from BUSY returns the bus outputs to zero.
                if (flush_i || wb_ack_i || (cnt_q == CNT_LAST)) begin
                    adr_d = '0;
                    dat_d = '0;
                    we_d  = 1'b0;
                    sel_d = '0;
                    stb_d = 1'b0;
                end

                if (flush_i) begin
                    rd_buf_d = '0;
                    state_d  = S_IDLE;
                end else if (wb_ack_i) begin
                    cpu_data_o = we_q ? '0 : wb_dat_i;
                    rd_buf_d   = we_q ? '0 : wb_dat_i;
                    state_d    = (stall_i != 6'd0) ? S_WAIT_STALL : S_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    rd_buf_d  = '0;
                    bus_err_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    stallreq_o = 1'b1;
                    cnt_d      = cnt_q + 1'b1;
                end
            end

            S_WAIT_STALL: begin
                cpu_data_o = rd_buf_q;
                if (flush_i) begin
                    rd_buf_d = '0;
                    state_d  = S_IDLE;
                end else if (stall_i == 6'd0) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign wb_adr_o  = adr_q;
    assign wb_dat_o  = dat_q;
    assign wb_we_o   = we_q;
    assign wb_sel_o  = sel_q;
    assign wb_stb_o  = stb_q;
    assign wb_cyc_o  = stb_q;
    assign bus_err_o = bus_err_q;

endmodule

// File: tb/tb_wishbone_bus_if.sv
// Directed bench for wishbone_bus_if with a short timeout (4 cycles) so the
// abort path is reachable quickly.
module tb_wishbone_bus_if;

    logic        clk;
    logic        rst;
    logic [5:0]  stall_i;
    logic        flush_i;
    logic        cpu_ce_i;
    logic [31:0] cpu_addr_i;
    logic [31:0] cpu_data_i;
    logic        cpu_we_i;
    logic [3:0]  cpu_sel_i;
    logic [31:0] cpu_data_o;
    logic        stallreq_o;
    logic        bus_err_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic        wb_we_o;
    logic [3:0]  wb_sel_o;
    logic        wb_stb_o;
    logic        wb_cyc_o;

    int vectors;
    int miscompares;

    wishbone_bus_if #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .stall_i    (stall_i),
        .flush_i    (flush_i),
        .cpu_ce_i   (cpu_ce_i),
        .cpu_addr_i (cpu_addr_i),
        .cpu_data_i (cpu_data_i),
        .cpu_we_i   (cpu_we_i),
        .cpu_sel_i  (cpu_sel_i),
        .cpu_data_o (cpu_data_o),
        .stallreq_o (stallreq_o),
        .bus_err_o  (bus_err_o),
        .wb_dat_i   (wb_dat_i),
        .wb_ack_i   (wb_ack_i),
        .wb_adr_o   (wb_adr_o),
        .wb_dat_o   (wb_dat_o),
        .wb_we_o    (wb_we_o),
        .wb_sel_o   (wb_sel_o),
        .wb_stb_o   (wb_stb_o),
        .wb_cyc_o   (wb_cyc_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs change here, checks follow #1.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        stall_i     = 6'd0;
        flush_i     = 1'b0;
        cpu_ce_i    = 1'b0;
        cpu_addr_i  = 32'd0;
        cpu_data_i  = 32'd0;
        cpu_we_i    = 1'b0;
        cpu_sel_i   = 4'd0;
        wb_dat_i    = 32'd0;
        wb_ack_i    = 1'b0;

        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_cyc",      {31'd0, wb_cyc_o},   32'd0);
        chk("rst_stb",      {31'd0, wb_stb_o},   32'd0);
        chk("rst_buserr",   {31'd0, bus_err_o},  32'd0);
        chk("rst_stallreq", {31'd0, stallreq_o}, 32'd0);
        chk("rst_adr",      wb_adr_o,            32'd0);
        chk("rst_cpudata",  cpu_data_o,          32'd0);

        // Read with ack two cycles after stb rises
        tick();
        cpu_ce_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h0000_0100;
        #1;
        chk("rd_req_stallreq", {31'd0, stallreq_o}, 32'd1);
        chk("rd_req_stb",      {31'd0, wb_stb_o},   32'd0);
        tick();
        cpu_ce_i = 1'b0;
        #1;
        chk("rd_b1_stb",      {31'd0, wb_stb_o},   32'd1);
        chk("rd_b1_cyc",      {31'd0, wb_cyc_o},   32'd1);
        chk("rd_b1_adr",      wb_adr_o,            32'h0000_0100);
        chk("rd_b1_we",       {31'd0, wb_we_o},    32'd0);
        chk("rd_b1_stallreq", {31'd0, stallreq_o}, 32'd1);
        tick();
        #1;
        chk("rd_b2_stallreq", {31'd0, stallreq_o}, 32'd1);
        tick();
        wb_ack_i = 1'b1; wb_dat_i = 32'hDEAD_BEEF;
        #1;
        chk("rd_ack_data",     cpu_data_o,          32'hDEAD_BEEF);
        chk("rd_ack_stallreq", {31'd0, stallreq_o}, 32'd0);
        tick();
        wb_ack_i = 1'b0;
        #1;
        chk("rd_done_cyc",     {31'd0, wb_cyc_o},   32'd0);
        chk("rd_done_adr",     wb_adr_o,            32'd0);
        chk("rd_done_cpudata", cpu_data_o,          32'd0);

        // Write acked in the first stb cycle
        tick();
        cpu_ce_i = 1'b1; cpu_we_i = 1'b1; cpu_sel_i = 4'b0011;
        cpu_data_i = 32'h1234_5678; cpu_addr_i = 32'h0000_0040;
        tick();
        cpu_ce_i = 1'b0; wb_ack_i = 1'b1; wb_dat_i = 32'h5555_AAAA;
        #1;
        chk("wr_sel",      {28'd0, wb_sel_o},   32'h3);
        chk("wr_dat",      wb_dat_o,            32'h1234_5678);
        chk("wr_we",       {31'd0, wb_we_o},    32'd1);
        chk("wr_adr",      wb_adr_o,            32'h0000_0040);
        chk("wr_stallreq", {31'd0, stallreq_o}, 32'd0);
        chk("wr_cpudata",  cpu_data_o,          32'd0);
        tick();
        wb_ack_i = 1'b0; cpu_we_i = 1'b0; cpu_sel_i = 4'd0;
        #1;
        chk("wr_done_stb", {31'd0, wb_stb_o}, 32'd0);
        chk("wr_done_dat", wb_dat_o,          32'd0);

        // Ack while the pipeline is stalled
        tick();
        stall_i = 6'b000011; cpu_ce_i = 1'b1; cpu_addr_i = 32'h0000_0200;
        tick();
        cpu_ce_i = 1'b0; wb_ack_i = 1'b1; wb_dat_i = 32'hCAFE_F00D;
        #1;
        chk("st_ack_data", cpu_data_o, 32'hCAFE_F00D);
        tick();
        wb_ack_i = 1'b0; cpu_ce_i = 1'b1; cpu_addr_i = 32'h0000_0999;
        #1;
        chk("st_w1_data",     cpu_data_o,          32'hCAFE_F00D);
        chk("st_w1_stallreq", {31'd0, stallreq_o}, 32'd0);
        chk("st_w1_stb",      {31'd0, wb_stb_o},   32'd0);
        tick();
        cpu_ce_i = 1'b0; stall_i = 6'd0;
        #1;
        chk("st_w2_stb",  {31'd0, wb_stb_o}, 32'd0);
        chk("st_w2_data", cpu_data_o,        32'hCAFE_F00D);
        tick();
        #1;
        chk("st_idle_data", cpu_data_o,        32'd0);
        chk("st_idle_stb",  {31'd0, wb_stb_o}, 32'd0);

        // Flush in the second BUSY cycle, then a late ack
        cpu_ce_i = 1'b1; cpu_addr_i = 32'h0000_0300;
        tick();
        cpu_ce_i = 1'b0;
        tick();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        #1;
        chk("fl_cyc",      {31'd0, wb_cyc_o},   32'd0);
        chk("fl_stb",      {31'd0, wb_stb_o},   32'd0);
        chk("fl_stallreq", {31'd0, stallreq_o}, 32'd0);
        wb_ack_i = 1'b1; wb_dat_i = 32'h1111_1111;
        #1;
        chk("fl_late_data",     cpu_data_o,          32'd0);
        chk("fl_late_stallreq", {31'd0, stallreq_o}, 32'd0);
        tick();
        wb_ack_i = 1'b0;
        #1;
        chk("fl_after_stb",  {31'd0, wb_stb_o}, 32'd0);
        chk("fl_after_data", cpu_data_o,        32'd0);

        // Timeout with TIMEOUT_CYC=4: stb held four cycles, single error pulse
        cpu_ce_i = 1'b1; cpu_addr_i = 32'h0000_0400;
        tick();
        cpu_ce_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("to_stb_%0d", i),    {31'd0, wb_stb_o},  32'd1);
            chk($sformatf("to_buserr_%0d", i), {31'd0, bus_err_o}, 32'd0);
            tick();
        end
        #1;
        chk("to_drop_stb",      {31'd0, wb_stb_o},   32'd0);
        chk("to_drop_buserr",   {31'd0, bus_err_o},  32'd1);
        chk("to_drop_cpudata",  cpu_data_o,          32'd0);
        chk("to_drop_stallreq", {31'd0, stallreq_o}, 32'd0);
        tick();
        #1;
        chk("to_pulse_end", {31'd0, bus_err_o}, 32'd0);

        // Asynchronous reset pulse in the middle of a BUSY cycle
        cpu_ce_i = 1'b1; cpu_addr_i = 32'h0000_0500;
        tick();
        cpu_ce_i = 1'b0;
        #1;
        chk("ar_pre_stb", {31'd0, wb_stb_o}, 32'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("ar_cyc",    {31'd0, wb_cyc_o},  32'd0);
        chk("ar_stb",    {31'd0, wb_stb_o},  32'd0);
        chk("ar_buserr", {31'd0, bus_err_o}, 32'd0);
        chk("ar_adr",    wb_adr_o,           32'd0);
        #1;
        rst = 1'b0;
        tick();
        cpu_ce_i = 1'b1; cpu_addr_i = 32'h0000_0600;
        #1;
        chk("ar_new_stallreq", {31'd0, stallreq_o}, 32'd1);
        tick();
        cpu_ce_i = 1'b0; wb_ack_i = 1'b1; wb_dat_i = 32'hA5A5_A5A5;
        #1;
        chk("ar_new_stb",  {31'd0, wb_stb_o}, 32'd1);
        chk("ar_new_adr",  wb_adr_o,          32'h0000_0600);
        chk("ar_new_data", cpu_data_o,        32'hA5A5_A5A5);
        tick();
        wb_ack_i = 1'b0;
        #1;
        chk("ar_new_done", {31'd0, wb_cyc_o}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
